loop_seq_ctrl: RTL and testbench

Sequencer and configuration owner for the ADC→DAC loopback datapath control inputs: `switch_loop`, `ri_sel` and `index` (2-bit arithmetic right-shift attenuation). It changes configuration only under a glitch-free mute/apply/settle sequence. It accepts manual reconfiguration requests over a valid/ready handshake. In loopback mode it also runs an automatic gain loop that measures the peak of the second-ADC samples and picks `index` to avoid DAC overdrive. It sits between the PS-side control registers and the loopback datapath, and drives a DAC-side mute.

---
 rtl/loop_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_loop_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/loop_seq_ctrl.sv
// Loopback config sequencer: glitch-free mute/apply/settle reconfiguration, manual requests plus window-peak automatic gain.
// Latency: config visible MUTE_CYCLES+1 cycles after accept; cfg_done pulses MUTE_CYCLES+SETTLE_CYCLES+2 cycles after accept.
// Backpressure: cfg_ready is high only in IDLE; a held request waits and is taken in the cfg_done cycle.
module loop_seq_ctrl #(
    parameter int MUTE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int WIN_LEN       = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic         cfg_loop,
    input  logic         cfg_ri_sel,
    input  logic [1:0]   cfg_index,
    input  logic         agc_en,
    input  logic [255:0] ad_in,
    output logic         switch_loop,
    output logic         ri_sel,
    output logic [1:0]   index,
    output logic         da_mute,
    output logic         cfg_done,
    output logic [15:0]  peak_last
);
    localparam int SEQ_MAX = (MUTE_CYCLES > SETTLE_CYCLES) ? MUTE_CYCLES : SETTLE_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int WIN_W   = $clog2(WIN_LEN);
    localparam logic [SEQ_W-1:0] MUTE_LAST   = SEQ_W'(MUTE_CYCLES - 1);
    localparam logic [SEQ_W-1:0] SETTLE_LAST = SEQ_W'(SETTLE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MUTE, ST_APPLY, ST_SETTLE} state_t;

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [15:0]      peak_q, peak_d, peak_last_q, peak_last_d;
    logic             switch_loop_q, switch_loop_d, ri_sel_q, ri_sel_d;
    logic [1:0]       index_q, index_d;
    logic             pend_loop_q, pend_loop_d, pend_ri_q, pend_ri_d;
    logic [1:0]       pend_index_q, pend_index_d;
    logic             cfg_done_q, cfg_done_d;
    logic             accept, agc_run, win_end, agc_start, seq_last, load;
    logic [15:0]      samp, mag, samp_max, peak_cur;
    logic [1:0]       new_index;
    logic             unused_ad;

    assign unused_ad = ^ad_in[127:0];

    // Only the upper half of the ADC word carries the second-ADC samples.
    always_comb begin
        samp     = '0;
        mag      = '0;
        samp_max = '0;
        for (int k = 0; k < 8; k++) begin
            samp = ad_in[128 + 16*k +: 16];
            if (samp == 16'h8000)
                mag = 16'h7fff;
            else if (samp[15])
                mag = -samp;
            else
                mag = samp;
            if (mag > samp_max)
                samp_max = mag;
        end
    end

    always_comb begin
        accept    = (state_q == ST_IDLE) && cfg_valid;
        agc_run   = (state_q == ST_IDLE) && agc_en && switch_loop_q;
        win_end   = agc_run && (win_cnt_q == WIN_LAST);
        peak_cur  = (samp_max > peak_q) ? samp_max : peak_q;
        if (peak_cur >= 16'h4000)
            new_index = 2'd3;
        else if (peak_cur >= 16'h2000)
            new_index = 2'd2;
        else if (peak_cur >= 16'h1000)
            new_index = 2'd1;
        else
            new_index = 2'd0;
        // A manual request on the window-end edge overrides the gain decision.
        agc_start = win_end && !accept && (new_index != index_q);
        seq_last  = ((state_q == ST_MUTE) && (seq_cnt_q == MUTE_LAST)) ||
                    ((state_q == ST_SETTLE) && (seq_cnt_q == SETTLE_LAST));
        load      = (state_q == ST_MUTE) && seq_last;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept || agc_start) state_d = ST_MUTE;
            ST_MUTE:   if (seq_last) state_d = ST_APPLY;
            ST_APPLY:  state_d = ST_SETTLE;
            ST_SETTLE: if (seq_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == ST_IDLE) && !rst;
        da_mute   = (state_q != ST_IDLE);
    end

    always_comb begin
        seq_cnt_d     = '0;
        win_cnt_d     = '0;
        peak_d        = '0;
        peak_last_d   = peak_last_q;
        switch_loop_d = switch_loop_q;
        ri_sel_d      = ri_sel_q;
        index_d       = index_q;
        pend_loop_d   = pend_loop_q;
        pend_ri_d     = pend_ri_q;
        pend_index_d  = pend_index_q;
        cfg_done_d    = (state_q == ST_SETTLE) && seq_last;

        if (((state_q == ST_MUTE) || (state_q == ST_SETTLE)) && !seq_last)
            seq_cnt_d = seq_cnt_q + SEQ_W'(1);

        // Counter and peak stay cleared whenever the gain loop is not running or IDLE is left.
        if (win_end) begin
            peak_last_d = peak_cur;
        end else if (agc_run && !accept) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            peak_d    = peak_cur;
        end

        if (accept) begin
            pend_loop_d  = cfg_loop;
            pend_ri_d    = cfg_ri_sel;
            pend_index_d = cfg_index;
        end else if (agc_start) begin
            pend_loop_d  = switch_loop_q;
            pend_ri_d    = ri_sel_q;
            pend_index_d = new_index;
        end

        if (load) begin
            switch_loop_d = pend_loop_q;
            ri_sel_d      = pend_ri_q;
            index_d       = pend_index_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_cnt_q     <= '0;
            win_cnt_q     <= '0;
            peak_q        <= '0;
            peak_last_q   <= '0;
            switch_loop_q <= 1'b1;
            ri_sel_q      <= 1'b1;
            index_q       <= 2'd0;
            pend_loop_q   <= 1'b1;
            pend_ri_q     <= 1'b1;
            pend_index_q  <= 2'd0;
            cfg_done_q    <= 1'b0;
        end else begin
            seq_cnt_q     <= seq_cnt_d;
            win_cnt_q     <= win_cnt_d;
            peak_q        <= peak_d;
            peak_last_q   <= peak_last_d;
            switch_loop_q <= switch_loop_d;
            ri_sel_q      <= ri_sel_d;
            index_q       <= index_d;
            pend_loop_q   <= pend_loop_d;
            pend_ri_q     <= pend_ri_d;
            pend_index_q  <= pend_index_d;
            cfg_done_q    <= cfg_done_d;
        end
    end

    assign switch_loop = switch_loop_q;
    assign ri_sel      = ri_sel_q;
    assign index       = index_q;
    assign cfg_done    = cfg_done_q;
    assign peak_last   = peak_last_q;

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// Directed bench for loop_seq_ctrl with default mute/settle lengths and a 16-cycle gain window.
module tb_loop_seq_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         cfg_loop;
    logic         cfg_ri_sel;
    logic [1:0]   cfg_index;
    logic         agc_en;
    logic [255:0] ad_in;
    logic         switch_loop;
    logic         ri_sel;
    logic [1:0]   index;
    logic         da_mute;
    logic         cfg_done;
    logic [15:0]  peak_last;

    int n_vec = 0;
    int n_err = 0;

    loop_seq_ctrl #(.MUTE_CYCLES(4), .SETTLE_CYCLES(4), .WIN_LEN(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_loop(cfg_loop), .cfg_ri_sel(cfg_ri_sel), .cfg_index(cfg_index),
        .agc_en(agc_en), .ad_in(ad_in),
        .switch_loop(switch_loop), .ri_sel(ri_sel), .index(index),
        .da_mute(da_mute), .cfg_done(cfg_done), .peak_last(peak_last)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_loop = 1'b0; cfg_ri_sel = 1'b0;
        cfg_index = 2'd0; agc_en = 1'b0; ad_in = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready cyc %0d: got %b want 0", i, cfg_ready); end
        end
        n_vec++;
        if ({switch_loop, ri_sel, index} !== 4'b1100) begin
            n_err++; $display("FAIL reset_cfg: got %b want 1100", {switch_loop, ri_sel, index});
        end
        n_vec++;
        if ({da_mute, cfg_done} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {da_mute, cfg_done}); end
        n_vec++;
        if (peak_last !== 16'h0) begin n_err++; $display("FAIL reset_peak: got %h want 0000", peak_last); end
        rst = 1'b0;
        step();
        n_vec++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b want 1", cfg_ready); end
    endtask

    task automatic test_manual();
        logic [3:0] exp_cfg;
        cfg_valid = 1'b1; cfg_loop = 1'b0; cfg_ri_sel = 1'b0; cfg_index = 2'd2;
        step();
        cfg_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            exp_cfg = (i >= 5) ? 4'b0010 : 4'b1100;
            n_vec++;
            if (da_mute !== (i <= 9)) begin n_err++; $display("FAIL manual_mute T+%0d: got %b want %b", i, da_mute, (i <= 9)); end
            n_vec++;
            if ({switch_loop, ri_sel, index} !== exp_cfg) begin
                n_err++; $display("FAIL manual_cfg T+%0d: got %b want %b", i, {switch_loop, ri_sel, index}, exp_cfg);
            end
            n_vec++;
            if (cfg_done !== (i == 10)) begin n_err++; $display("FAIL manual_done T+%0d: got %b want %b", i, cfg_done, (i == 10)); end
            n_vec++;
            if (cfg_ready !== (i == 10)) begin n_err++; $display("FAIL manual_ready T+%0d: got %b want %b", i, cfg_ready, (i == 10)); end
            if (i < 10) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_cfg;
        logic       exp_mute, exp_pulse;
        cfg_valid = 1'b1; cfg_loop = 1'b1; cfg_ri_sel = 1'b1; cfg_index = 2'd1;
        step();
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) cfg_index = 2'd3;
            exp_cfg   = (i >= 15) ? 4'b1111 : (i >= 5) ? 4'b1101 : 4'b0010;
            exp_mute  = (i >= 1 && i <= 9) || (i >= 11 && i <= 19);
            exp_pulse = (i == 10) || (i == 20);
            n_vec++;
            if (da_mute !== exp_mute) begin n_err++; $display("FAIL b2b_mute T+%0d: got %b want %b", i, da_mute, exp_mute); end
            n_vec++;
            if ({switch_loop, ri_sel, index} !== exp_cfg) begin
                n_err++; $display("FAIL b2b_cfg T+%0d: got %b want %b", i, {switch_loop, ri_sel, index}, exp_cfg);
            end
            n_vec++;
            if (cfg_done !== exp_pulse) begin n_err++; $display("FAIL b2b_done T+%0d: got %b want %b", i, cfg_done, exp_pulse); end
            n_vec++;
            if (cfg_ready !== exp_pulse) begin n_err++; $display("FAIL b2b_ready T+%0d: got %b want %b", i, cfg_ready, exp_pulse); end
            if (i < 20) step();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_agc();
        logic [15:0] tab_samp [5]  = '{16'h2400, 16'h8000, 16'h0800, 16'hdfff, 16'h0123};
        int          tab_k    [5]  = '{3, 0, -1, 7, -1};
        logic [15:0] tab_peak [5]  = '{16'h2400, 16'h7fff, 16'h0800, 16'h2001, 16'h0123};
        logic [1:0]  tab_idx  [5]  = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
        logic [1:0]  old_idx;
        logic [1:0]  exp_idx;
        agc_en = 1'b0;
        step();
        for (int w = 0; w < 5; w++) begin
            ad_in = '0;
            for (int k = 0; k < 8; k++)
                if (tab_k[w] < 0 || tab_k[w] == k) ad_in[128 + 16*k +: 16] = tab_samp[w];
            // Noise in the unused lower half must not affect the peak.
            ad_in[127:0] = {8{16'h7abc}};
            agc_en  = 1'b1;
            old_idx = index;
            for (int c = 0; c < 16; c++) step();
            n_vec++;
            if (peak_last !== tab_peak[w]) begin n_err++; $display("FAIL agc_peak win %0d: got %h want %h", w, peak_last, tab_peak[w]); end
            for (int i = 1; i <= 10; i++) begin
                exp_idx = (i >= 5) ? tab_idx[w] : old_idx;
                n_vec++;
                if (da_mute !== (i <= 9)) begin n_err++; $display("FAIL agc_mute win %0d T+%0d: got %b want %b", w, i, da_mute, (i <= 9)); end
                n_vec++;
                if (index !== exp_idx) begin n_err++; $display("FAIL agc_index win %0d T+%0d: got %0d want %0d", w, i, index, exp_idx); end
                if (i < 10) step();
            end
            n_vec++;
            if (cfg_done !== 1'b1) begin n_err++; $display("FAIL agc_done win %0d: got %b want 1", w, cfg_done); end
        end
    endtask

    task automatic test_agc_abort();
        ad_in = '0;
        ad_in[128 +: 16] = 16'h4000;
        agc_en = 1'b1;
        for (int c = 0; c < 10; c++) step();
        agc_en = 1'b0;
        step();
        n_vec++;
        if (peak_last !== 16'h0123) begin n_err++; $display("FAIL abort_peak_held: got %h want 0123", peak_last); end
        agc_en = 1'b1;
        ad_in = '0;
        for (int c = 0; c < 16; c++) step();
        n_vec++;
        if (peak_last !== 16'h0000) begin n_err++; $display("FAIL abort_peak_new: got %h want 0000", peak_last); end
        n_vec++;
        if ({da_mute, index} !== 3'b000) begin n_err++; $display("FAIL abort_no_seq: got %b want 000", {da_mute, index}); end
    endtask

    task automatic test_collision();
        agc_en = 1'b0;
        step();
        ad_in = '0;
        ad_in[128 + 16*5 +: 16] = 16'h4000;
        agc_en = 1'b1;
        for (int c = 0; c < 15; c++) step();
        cfg_valid = 1'b1; cfg_loop = 1'b1; cfg_ri_sel = 1'b1; cfg_index = 2'd1;
        step();
        cfg_valid = 1'b0;
        n_vec++;
        if (peak_last !== 16'h4000) begin n_err++; $display("FAIL coll_peak: got %h want 4000", peak_last); end
        for (int i = 1; i <= 10; i++) begin
            n_vec++;
            if (index !== ((i >= 5) ? 2'd1 : 2'd0)) begin
                n_err++; $display("FAIL coll_index T+%0d: got %0d want %0d", i, index, (i >= 5) ? 1 : 0);
            end
            if (i < 10) step();
        end
        n_vec++;
        if (cfg_done !== 1'b1) begin n_err++; $display("FAIL coll_done: got %b want 1", cfg_done); end
        agc_en = 1'b0;
        step();
        n_vec++;
        if ({da_mute, cfg_done, index} !== 4'b0001) begin
            n_err++; $display("FAIL coll_single_seq: got %b want 0001", {da_mute, cfg_done, index});
        end
    endtask

    task automatic test_reset_mid();
        cfg_valid = 1'b1; cfg_loop = 1'b1; cfg_ri_sel = 1'b0; cfg_index = 2'd2;
        step();
        cfg_valid = 1'b0;
        step();
        step();
        n_vec++;
        if (da_mute !== 1'b1) begin n_err++; $display("FAIL rmid_mute_pre: got %b want 1", da_mute); end
        rst = 1'b1;
        step();
        n_vec++;
        if ({da_mute, switch_loop, ri_sel, index} !== 5'b01100) begin
            n_err++; $display("FAIL rmid_state: got %b want 01100", {da_mute, switch_loop, ri_sel, index});
        end
        n_vec++;
        if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready_in_rst: got %b want 0", cfg_ready); end
        rst = 1'b0;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", cfg_ready); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if ({cfg_done, da_mute, index} !== 4'b0000) begin
                n_err++; $display("FAIL rmid_quiet cyc %0d: got %b want 0000", i, {cfg_done, da_mute, index});
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_back_to_back();
        test_agc();
        test_agc_abort();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
